// File: rtl/fwd_hazard_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fwd_hazard_tracker_pkg
// Brief   : Shared slot record, forward-select constants and select width.
// Revision: 1.0 - initial release
// ============================================================================
package fwd_hazard_tracker_pkg;

    // Slot fields are sized for the largest supported configuration.
    // Narrower addresses and latencies are zero-extended into them.
    localparam int c_MAX_RD_W  = 8;
    localparam int c_MAX_LAT_W = 4;

    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    typedef struct packed {
        logic                   valid;
        logic [c_MAX_RD_W-1:0]  rd;
        logic [c_MAX_LAT_W-1:0] lat;
    } slot_t;

    function automatic int sel_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_tracker_if.sv
`default_nettype none
// ============================================================================
// Module  : fwd_hazard_tracker_if
// Brief   : ID-stage issue/operand bus and tracker results.
// Revision: 1.0 - initial release
// ============================================================================
interface fwd_hazard_tracker_if
    import fwd_hazard_tracker_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LAT_W      = 2,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = sel_width(DEPTH);

    logic                          i_issue_valid;
    logic                          i_issue_regwrite;
    logic [REG_ADDR_W-1:0]         i_issue_rd;
    logic [LAT_W-1:0]              i_issue_lat;
    logic [NUM_SRC*REG_ADDR_W-1:0] i_src_addr;
    logic [NUM_SRC-1:0]            i_src_used;
    logic                          i_halt;
    logic                          i_flush;
    logic                          o_stall;
    logic [NUM_SRC*SEL_W-1:0]      o_fwd_sel;
    logic [CNT_W-1:0]              o_stall_cycles;

    modport master (
        output i_issue_valid, i_issue_regwrite, i_issue_rd, i_issue_lat,
               i_src_addr, i_src_used, i_halt, i_flush,
        input  o_stall, o_fwd_sel, o_stall_cycles
    );

    modport slave (
        input  i_issue_valid, i_issue_regwrite, i_issue_rd, i_issue_lat,
               i_src_addr, i_src_used, i_halt, i_flush,
        output o_stall, o_fwd_sel, o_stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/fwd_hazard_tracker_operand_match.sv
`default_nettype none
// ============================================================================
// Module  : fwd_operand_match
// Brief   : Priority scan of in-flight writers for one source operand.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_operand_match
    import fwd_hazard_tracker_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = 2
)
(
    input  slot_t [DEPTH-1:1]     i_slots,
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_used,
    output logic                  o_hit,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_hazard
);

    logic [c_MAX_RD_W-1:0] w_src;

    assign w_src = c_MAX_RD_W'(i_src);

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        o_hit    = 1'b0;
        o_sel    = '0;
        o_hazard = 1'b0;
        for (int j = DEPTH - 1; j >= 1; j--) begin
            if (i_used && i_slots[j].valid && (i_slots[j].rd == w_src)) begin
                o_hit    = 1'b1;
                o_sel    = SEL_W'(j);
                o_hazard = (int'(i_slots[j].lat) > j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module  : fwd_hazard_tracker
// Brief   : In-flight writer record, load-use stall and registered forward selects.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_hazard_tracker
    import fwd_hazard_tracker_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LAT_W      = 2,
    parameter int CNT_W      = 16
)
(
    input  logic                i_clk,
    input  logic                i_reset,
    fwd_hazard_tracker_if.slave bus
);

    localparam int SEL_W = sel_width(DEPTH);

    // The oldest stage writes the register file this cycle and the register
    // file is write-first, so only stages EX..DEPTH-1 need a record.
    slot_t [DEPTH-1:1]          r_slots;
    logic [NUM_SRC*SEL_W-1:0]   r_fwd_sel;
    logic [CNT_W-1:0]           r_stall_cnt;

    logic [NUM_SRC-1:0]         w_hit;
    logic [NUM_SRC-1:0]         w_hazard;
    logic [SEL_W-1:0]           w_sel [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0]   w_sel_next;
    logic                       w_hazard_any;
    logic [LAT_W-1:0]           w_lat_raw;
    logic [c_MAX_LAT_W-1:0]     w_issue_lat;
    slot_t                      w_issue;

    generate
        for (genvar n = 0; n < NUM_SRC; n++) begin : g_operand
            fwd_operand_match #(
                .REG_ADDR_W (REG_ADDR_W),
                .DEPTH      (DEPTH),
                .SEL_W      (SEL_W)
            ) u_match (
                .i_slots  (r_slots),
                .i_src    (bus.i_src_addr[n*REG_ADDR_W +: REG_ADDR_W]),
                .i_used   (bus.i_src_used[n]),
                .o_hit    (w_hit[n]),
                .o_sel    (w_sel[n]),
                .o_hazard (w_hazard[n])
            );
            assign w_sel_next[n*SEL_W +: SEL_W] = w_hit[n] ? w_sel[n] : SEL_W'(FWD_RF);
        end
    endgenerate

    assign w_hazard_any = |w_hazard;
    assign w_lat_raw    = bus.i_issue_lat;

    // Out-of-range latencies are pulled into 1..DEPTH-1.
    always_comb begin
        if (w_lat_raw == '0) begin
            w_issue_lat = c_MAX_LAT_W'(FWD_MEM);
        end else if (int'(w_lat_raw) > DEPTH - 1) begin
            w_issue_lat = c_MAX_LAT_W'(DEPTH - 1);
        end else begin
            w_issue_lat = c_MAX_LAT_W'(w_lat_raw);
        end
    end

    always_comb begin
        w_issue       = '0;
        w_issue.valid = bus.i_issue_valid && bus.i_issue_regwrite && (bus.i_issue_rd != '0);
        w_issue.rd    = c_MAX_RD_W'(bus.i_issue_rd);
        w_issue.lat   = w_issue_lat;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slots     <= '0;
            r_fwd_sel   <= '0;
            r_stall_cnt <= '0;
        end else if (!bus.i_halt) begin
            for (int k = DEPTH - 1; k >= 2; k--) begin
                r_slots[k] <= r_slots[k-1];
            end
            if (bus.i_flush || w_hazard_any) begin
                r_slots[1] <= '0;
                r_fwd_sel  <= '0;
            end else begin
                r_slots[1] <= w_issue;
                r_fwd_sel  <= w_sel_next;
            end
            if (!bus.i_flush && w_hazard_any && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.o_stall        = w_hazard_any & ~bus.i_halt & ~bus.i_flush & ~i_reset;
    assign bus.o_fwd_sel      = r_fwd_sel;
    assign bus.o_stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire
